load_store_unit: RTL

- Sits between the pipeline MEM stage and the word-addressed data memory. The memory has a registered read with 1-cycle latency and word-only writes.
- Handles the RV32I load and store widths:
  - loads: LB, LH, LW, LBU, LHU, with byte-lane extraction and sign or zero extension;
  - stores: SW directly, SB and SH as read-modify-write.
- Checks alignment and funct3 legality, and stalls the pipeline through a valid/ready handshake.

---
 rtl/load_store_unit.sv | 90 +++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I load/store sequencer for a 1-cycle registered-read, word-write data memory.
module load_store_unit #(
  parameter int Width = 32,
  parameter int AddrBits = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic             req_write,
  input  logic [2:0]       funct3,
  input  logic [Width-1:0] addr,
  input  logic [Width-1:0] wdata,
  output logic             req_ready,
  output logic             resp_valid,
  output logic [Width-1:0] rdata,
  output logic             fault,
  output logic             MemRead,
  output logic             MemWrite,
  output logic [Width-1:0] MemAddr,
  output logic [Width-1:0] MemWriteData,
  input  logic [Width-1:0] MemReadData
);
  typedef enum logic [2:0] {IDLE, ERR, RD, RD_WAIT, RMW_RD, RMW_WAIT, WR, RESP} state_t;
  state_t state, state_nx;
  logic [2:0] f3_q;
  logic [1:0] off_q;
  logic [AddrBits-1:0] waddr_q;
  logic [Width-1:0] wd_q, rdata_q, ld, merged, mask, lane;
  logic [7:0] b;
  logic [15:0] h;
  logic legal, misal, bad, accept, unused;
  assign unused = ^addr[Width-1:AddrBits+2];
  assign legal = req_write ? funct3 inside {3'b000, 3'b001, 3'b010}
                           : funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
  assign misal = (funct3[1:0] == 2'b01 && addr[0]) || (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00);
  assign bad = !legal || misal;
  assign accept = state == IDLE && req_valid;
  assign b = MemReadData[{off_q, 3'b000} +: 8];
  assign h = MemReadData[{off_q[1], 4'b0000} +: 16];
  assign ld = f3_q[1:0] == 2'b00 ? {{(Width-8){~f3_q[2] & b[7]}}, b}
            : f3_q[1:0] == 2'b01 ? {{(Width-16){~f3_q[2] & h[15]}}, h}
            : MemReadData;
  // SB/SH: replicate the new lane across the word and let the mask pick its slot
  assign mask = f3_q[0] ? Width'(16'hFFFF) << {off_q[1], 4'b0000} : Width'(8'hFF) << {off_q, 3'b000};
  assign lane = f3_q[0] ? {(Width/16){wd_q[15:0]}} : {(Width/8){wd_q[7:0]}};
  assign merged = (MemReadData & ~mask) | (lane & mask);
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     state_nx = !req_valid ? IDLE : bad ? ERR : !req_write ? RD : funct3 == 3'b010 ? WR : RMW_RD;
      RD:       state_nx = RD_WAIT;
      RD_WAIT:  state_nx = RESP;
      RMW_RD:   state_nx = RMW_WAIT;
      RMW_WAIT: state_nx = WR;
      WR:       state_nx = RESP;
      default:  state_nx = IDLE;
    endcase
  end
  always_comb begin
    req_ready = state == IDLE;
    resp_valid = state == ERR || state == RESP;
    fault = state == ERR;
    MemRead = state == RD || state == RMW_RD;
    MemWrite = state == WR;
  end
  assign MemAddr = Width'(waddr_q);
  assign MemWriteData = MemWrite ? wd_q : '0;
  assign rdata = rdata_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      f3_q <= '0;
      off_q <= '0;
      waddr_q <= '0;
      wd_q <= '0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        f3_q <= funct3;
        off_q <= addr[1:0];
        waddr_q <= addr[AddrBits+1:2];
        wd_q <= wdata;
        if (bad) rdata_q <= '0;
      end
      if (state == RD_WAIT) rdata_q <= ld;
      if (state == RMW_WAIT) wd_q <= merged;
    end
endmodule
